// File: rtl/vs_regfile_sb.sv
// Unified scalar/vector register file: two broadcast read ports, per-register busy scoreboard,
// and one write port shared by the ALU and an ordered memory pending buffer. Define VS_REGFILE_BYPASS_EN for write-to-read bypass.
module vs_regfile_sb #(
  parameter int registerSize   = 8,
  parameter int vectorSize     = 4,
  parameter int vecQuantity    = 8,
  parameter int scalarQuantity = 16,
  parameter int selectionBits  = 5,
  parameter int pendDepth      = 2
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic [selectionBits-1:0]               rSel1,
  input  logic [selectionBits-1:0]               rSel2,
  output logic [vectorSize-1:0][registerSize-1:0] operand1,
  output logic [vectorSize-1:0][registerSize-1:0] operand2,
  output logic                                   hazard1,
  output logic                                   hazard2,
  input  logic                                   issueValid,
  input  logic [selectionBits-1:0]               issueDest,
  output logic                                   issueReady,
  input  logic                                   wrEnAlu,
  input  logic [selectionBits-1:0]               wrSelAlu,
  input  logic [vectorSize-1:0][registerSize-1:0] wrDataAlu,
  input  logic [vectorSize-1:0]                  wrMaskAlu,
  input  logic                                   wrEnMem,
  input  logic [selectionBits-1:0]               wrSelMem,
  input  logic [vectorSize-1:0][registerSize-1:0] wrDataMem,
  input  logic [vectorSize-1:0]                  wrMaskMem,
  output logic                                   memReady
);

  localparam int IdxW    = selectionBits - 1;
  localparam int VecIdxW = (vecQuantity > 1) ? $clog2(vecQuantity) : 1;
  localparam int ScaIdxW = (scalarQuantity > 1) ? $clog2(scalarQuantity) : 1;
  localparam int PtrW    = (pendDepth > 1) ? $clog2(pendDepth) : 1;
  localparam int CntW    = $clog2(pendDepth + 1);

`ifdef VS_REGFILE_BYPASS_EN
  localparam bit BypassEn = 1'b1;
`else
  localparam bit BypassEn = 1'b0;
`endif

  typedef logic [selectionBits-1:0]               sel_t;
  typedef logic [vectorSize-1:0][registerSize-1:0] lanes_t;
  typedef logic [vectorSize-1:0]                  mask_t;
  typedef logic [PtrW-1:0]                        ptr_t;
  typedef logic [CntW-1:0]                        cnt_t;

  typedef struct packed {
    sel_t   sel;
    lanes_t data;
    mask_t  mask;
  } wr_req_t;

  typedef struct packed {
    logic               scalar;
    logic               valid;
    logic [VecIdxW-1:0] vidx;
    logic [ScaIdxW-1:0] sidx;
  } dec_t;

  // Split a select into bank, in-range flag and bank index.
  function automatic dec_t decode(input sel_t s);
    dec_t        d;
    logic [31:0] idx;
    idx      = 32'(s[IdxW-1:0]);
    d.scalar = s[selectionBits-1];
    d.valid  = d.scalar ? (idx < 32'(scalarQuantity)) : (idx < 32'(vecQuantity));
    d.vidx   = s[VecIdxW-1:0];
    d.sidx   = s[ScaIdxW-1:0];
    return d;
  endfunction

  function automatic lanes_t merge_lanes(input lanes_t old, input lanes_t data, input mask_t mask);
    lanes_t r;
    r = old;
    for (int i = 0; i < vectorSize; i++) begin
      if (mask[i]) r[i] = data[i];
    end
    return r;
  endfunction

  function automatic ptr_t ptr_inc(input ptr_t p);
    return (p == ptr_t'(pendDepth - 1)) ? '0 : p + ptr_t'(1);
  endfunction

  // Architectural state
  lanes_t                  vec_q   [vecQuantity];
  lanes_t                  vec_d   [vecQuantity];
  logic [registerSize-1:0] sca_q   [scalarQuantity];
  logic [registerSize-1:0] sca_d   [scalarQuantity];
  logic [vecQuantity-1:0]    vbusy_q, vbusy_d;
  logic [scalarQuantity-1:0] sbusy_q, sbusy_d;

  // Memory pending buffer
  wr_req_t pend_q [pendDepth];
  wr_req_t pend_d [pendDepth];
  ptr_t    head_q, head_d, tail_q, tail_d;
  cnt_t    count_q, count_d;

  wr_req_t alu_req, mem_req, port_req;
  dec_t    port_dec, issue_dec;
  logic    pend_empty, head_drain, mem_accept, mem_direct, mem_push;
  logic    port_we, port_commit, issue_busy, issue_set;

  assign alu_req = '{sel: wrSelAlu, data: wrDataAlu, mask: wrMaskAlu};
  assign mem_req = '{sel: wrSelMem, data: wrDataMem, mask: wrMaskMem};

  // Write-port arbitration: ALU, then buffer head, then a direct memory write.
  assign pend_empty = (count_q == '0);
  assign head_drain = !wrEnAlu && !pend_empty;
  assign memReady   = (count_q < cnt_t'(pendDepth)) || head_drain;
  assign mem_accept = wrEnMem && memReady;
  assign mem_direct = mem_accept && !wrEnAlu && pend_empty;
  assign mem_push   = mem_accept && !mem_direct;

  always_comb begin : port_arb
    // NOTE: every variable driven in always_comb gets a default first, so no path can infer a latch.
    port_req = mem_req;
    if (wrEnAlu)          port_req = alu_req;
    else if (!pend_empty) port_req = pend_q[head_q];
  end

  assign port_we  = wrEnAlu || head_drain || mem_direct;
  assign port_dec = decode(port_req.sel);
  // Reset is folded in so nothing can bypass onto the operands while the file is held in reset.
  assign port_commit = port_we && port_dec.valid && reset;

  always_comb begin : issue_check
    issue_dec  = decode(issueDest);
    issue_busy = 1'b0;
    if (issue_dec.valid) begin
      issue_busy = issue_dec.scalar ? sbusy_q[issue_dec.sidx] : vbusy_q[issue_dec.vidx];
    end
  end

  assign issueReady = !issue_busy;
  assign issue_set  = issueValid && issueReady && issue_dec.valid;

  sel_t   rd_sel  [2];
  lanes_t rd_data [2];
  logic   rd_haz  [2];

  assign rd_sel[0] = rSel1;
  assign rd_sel[1] = rSel2;

  always_comb begin : read_path
    dec_t d;
    logic busy;
    logic hit;
    d    = '0;
    busy = 1'b0;
    hit  = 1'b0;
    for (int p = 0; p < 2; p++) begin
      d          = decode(rd_sel[p]);
      rd_data[p] = '0;
      busy       = 1'b0;
      hit        = 1'b0;
      if (d.valid) begin
        if (d.scalar) begin
          rd_data[p] = {vectorSize{sca_q[d.sidx]}};
          busy       = sbusy_q[d.sidx];
        end else begin
          rd_data[p] = vec_q[d.vidx];
          busy       = vbusy_q[d.vidx];
        end
        hit = BypassEn && port_commit && (port_req.sel == rd_sel[p]);
        if (hit) begin
          rd_data[p] = d.scalar ? lanes_t'({vectorSize{port_req.data[0]}})
                                : merge_lanes(rd_data[p], port_req.data, port_req.mask);
        end
      end
      rd_haz[p] = busy && !hit;
    end
  end

  assign operand1 = rd_data[0];
  assign operand2 = rd_data[1];
  assign hazard1  = rd_haz[0];
  assign hazard2  = rd_haz[1];

  always_comb begin : state_next
    vec_d   = vec_q;
    sca_d   = sca_q;
    vbusy_d = vbusy_q;
    sbusy_d = sbusy_q;
    if (port_commit) begin
      if (port_dec.scalar) begin
        sca_d[port_dec.sidx]   = port_req.data[0];
        sbusy_d[port_dec.sidx] = 1'b0;
      end else begin
        vec_d[port_dec.vidx]   = merge_lanes(vec_q[port_dec.vidx], port_req.data, port_req.mask);
        vbusy_d[port_dec.vidx] = 1'b0;
      end
    end
    // Applied after the clear so a same-cycle issue leaves the register busy.
    if (issue_set) begin
      if (issue_dec.scalar) sbusy_d[issue_dec.sidx] = 1'b1;
      else                  vbusy_d[issue_dec.vidx] = 1'b1;
    end
  end

  always_comb begin : pend_next
    pend_d  = pend_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (mem_push) begin
      pend_d[tail_q] = mem_req;
      tail_d         = ptr_inc(tail_q);
    end
    if (head_drain) head_d = ptr_inc(head_q);
    case ({mem_push, head_drain})
      2'b10:   count_d = count_q + cnt_t'(1);
      2'b01:   count_d = count_q - cnt_t'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < vecQuantity; i++)    vec_q[i] <= '0;
      for (int i = 0; i < scalarQuantity; i++) sca_q[i] <= '0;
      vbusy_q <= '0;
      sbusy_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of statement order.
      vec_q   <= vec_d;
      sca_q   <= sca_d;
      vbusy_q <= vbusy_d;
      sbusy_q <= sbusy_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // NOTE: buffer payload is deliberately not reset; an entry is only read while count covers it.
  always_ff @(posedge clk) begin
    pend_q <= pend_d;
  end

endmodule

// File: tb/tb_vs_regfile_sb.sv
// Self-checking bench for vs_regfile_sb: queue/array reference model compared every cycle,
// plus directed vectors with hand-computed literal expectations.
module tb_vs_regfile_sb;

  localparam int VQ = 8;
  localparam int SQ = 16;
  localparam int PD = 2;

`ifdef VS_REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset;
  logic [4:0]       rSel1, rSel2, issueDest, wrSelAlu, wrSelMem;
  logic [3:0][7:0]  operand1, operand2, wrDataAlu, wrDataMem;
  logic [3:0]       wrMaskAlu, wrMaskMem;
  logic             hazard1, hazard2, issueValid, issueReady, wrEnAlu, wrEnMem, memReady;

  int n_checks = 0;
  int n_pass   = 0;

  vs_regfile_sb dut (
    .clk(clk), .reset(reset),
    .rSel1(rSel1), .rSel2(rSel2),
    .operand1(operand1), .operand2(operand2),
    .hazard1(hazard1), .hazard2(hazard2),
    .issueValid(issueValid), .issueDest(issueDest), .issueReady(issueReady),
    .wrEnAlu(wrEnAlu), .wrSelAlu(wrSelAlu), .wrDataAlu(wrDataAlu), .wrMaskAlu(wrMaskAlu),
    .wrEnMem(wrEnMem), .wrSelMem(wrSelMem), .wrDataMem(wrDataMem), .wrMaskMem(wrMaskMem),
    .memReady(memReady)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
    n_checks++;
    if (actual === expected) n_pass++;
    else $display("FAIL %s: actual=0x%0h required=0x%0h", name, actual, expected);
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [4:0]      sel;
    logic [3:0][7:0] data;
    logic [3:0]      mask;
  } req_t;

  bit [7:0] m_vec   [VQ][4];
  bit [7:0] m_sca   [SQ];
  bit       m_vbusy [VQ];
  bit       m_sbusy [SQ];
  req_t     m_pend  [$];

  function automatic bit m_valid(input logic [4:0] s);
    int idx;
    idx = int'(s[3:0]);
    return s[4] ? (idx < SQ) : (idx < VQ);
  endfunction

  function automatic logic [31:0] m_value(input logic [4:0] s);
    logic [31:0] v;
    int idx;
    v   = '0;
    idx = int'(s[3:0]);
    if (m_valid(s)) begin
      if (s[4]) v = {4{m_sca[idx]}};
      else for (int l = 0; l < 4; l++) v[8*l +: 8] = m_vec[idx][l];
    end
    return v;
  endfunction

  function automatic bit m_busy(input logic [4:0] s);
    int idx;
    idx = int'(s[3:0]);
    if (!m_valid(s)) return 1'b0;
    return s[4] ? m_sbusy[idx] : m_vbusy[idx];
  endfunction

  // Which request owns the write port this cycle, if any.
  function automatic bit m_port(output req_t w);
    w = '{sel: wrSelMem, data: wrDataMem, mask: wrMaskMem};
    if (wrEnAlu) begin
      w = '{sel: wrSelAlu, data: wrDataAlu, mask: wrMaskAlu};
      return 1'b1;
    end
    if (m_pend.size() > 0) begin
      w = m_pend[0];
      return 1'b1;
    end
    return wrEnMem;
  endfunction

  function automatic bit m_mem_ready();
    return (m_pend.size() < PD) || (m_pend.size() == PD && !wrEnAlu);
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] s, output bit hit);
    logic [31:0] v;
    req_t w;
    bit we;
    v   = m_value(s);
    hit = 1'b0;
    we  = m_port(w);
    if (BYP && reset === 1'b1 && we && w.sel == s && m_valid(s)) begin
      hit = 1'b1;
      if (s[4]) v = {4{w.data[0]}};
      else for (int l = 0; l < 4; l++) if (w.mask[l]) v[8*l +: 8] = w.data[l];
    end
    return v;
  endfunction

  always @(posedge clk or negedge reset) begin : model_update
    req_t w;
    bit   we, rdy, had_pend, issue_ok;
    int   idx;
    if (!reset) begin
      foreach (m_vec[i, l]) m_vec[i][l] = '0;
      foreach (m_sca[i])    m_sca[i]    = '0;
      foreach (m_vbusy[i])  m_vbusy[i]  = 1'b0;
      foreach (m_sbusy[i])  m_sbusy[i]  = 1'b0;
      m_pend.delete();
    end else begin
      rdy      = m_mem_ready();
      we       = m_port(w);
      had_pend = (m_pend.size() > 0);
      issue_ok = issueValid && !m_busy(issueDest) && m_valid(issueDest);
      if (we && m_valid(w.sel)) begin
        idx = int'(w.sel[3:0]);
        if (w.sel[4]) begin
          m_sca[idx]   = w.data[0];
          m_sbusy[idx] = 1'b0;
        end else begin
          for (int l = 0; l < 4; l++) if (w.mask[l]) m_vec[idx][l] = w.data[l];
          m_vbusy[idx] = 1'b0;
        end
      end
      if (!wrEnAlu && had_pend) void'(m_pend.pop_front());
      if (wrEnMem && rdy && (wrEnAlu || had_pend))
        m_pend.push_back('{sel: wrSelMem, data: wrDataMem, mask: wrMaskMem});
      if (issue_ok) begin
        idx = int'(issueDest[3:0]);
        if (issueDest[4]) m_sbusy[idx] = 1'b1;
        else              m_vbusy[idx] = 1'b1;
      end
    end
  end

  always @(negedge clk) begin : compare
    logic [31:0] e1, e2;
    bit h1, h2;
    e1 = m_read(rSel1, h1);
    e2 = m_read(rSel2, h2);
    check($sformatf("model operand1 t=%0t", $time), operand1, e1);
    check($sformatf("model operand2 t=%0t", $time), operand2, e2);
    check($sformatf("model hazard1 t=%0t", $time), hazard1, m_busy(rSel1) && !h1);
    check($sformatf("model hazard2 t=%0t", $time), hazard2, m_busy(rSel2) && !h2);
    check($sformatf("model issueReady t=%0t", $time), issueReady, !m_busy(issueDest));
    check($sformatf("model memReady t=%0t", $time), memReady, m_mem_ready());
  end

  // ---------------- stimulus ----------------
  function automatic logic [4:0] vsel(input int n);
    return {1'b0, 4'(n)};
  endfunction

  function automatic logic [4:0] ssel(input int n);
    return {1'b1, 4'(n)};
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wrEnAlu = 1'b0; wrSelAlu = '0; wrDataAlu = '0; wrMaskAlu = '0;
    wrEnMem = 1'b0; wrSelMem = '0; wrDataMem = '0; wrMaskMem = '0;
    issueValid = 1'b0; issueDest = '0;
  endtask

  task automatic alu(input logic [4:0] sel, input logic [31:0] data, input logic [3:0] mask);
    wrEnAlu = 1'b1; wrSelAlu = sel; wrDataAlu = data; wrMaskAlu = mask;
  endtask

  task automatic mem(input logic [4:0] sel, input logic [31:0] data, input logic [3:0] mask);
    wrEnMem = 1'b1; wrSelMem = sel; wrDataMem = data; wrMaskMem = mask;
  endtask

  task automatic issue(input logic [4:0] sel);
    issueValid = 1'b1; issueDest = sel;
  endtask

  initial begin
    reset = 1'b0;
    rSel1 = '0;
    rSel2 = '0;
    idle();
    cyc(); cyc();
    #3;
    check("rst operand1", operand1, 32'h0);
    check("rst hazard1", hazard1, 1'b0);
    check("rst issueReady", issueReady, 1'b1);
    check("rst memReady", memReady, 1'b1);
    cyc();
    reset = 1'b1;

    // Write V1, buffer V4 behind an ALU write, then reset mid-stream.
    cyc(); idle();
    alu(vsel(1), 32'h11111111, 4'hF); mem(vsel(4), 32'h44444444, 4'hF);
    rSel1 = vsel(1);
    #3 check("first mem accepted", memReady, 1'b1);
    cyc(); idle();
    alu(vsel(6), 32'h66666666, 4'hF);
    rSel1 = vsel(1); rSel2 = vsel(4);
    #2;
    check("v1 written", operand1, 32'h11111111);
    check("v4 still buffered", operand2, 32'h0);
    #1 reset = 1'b0;
    #2;
    check("mid reset v1", operand1, 32'h0);
    check("mid reset memReady", memReady, 1'b1);
    check("mid reset issueReady", issueReady, 1'b1);
    cyc(); reset = 1'b1; idle();
    rSel1 = vsel(1); rSel2 = vsel(4);
    cyc();
    #3;
    check("buffer flushed v4", operand2, 32'h0);
    check("v1 cleared", operand1, 32'h0);

    // Masked vector write.
    cyc(); idle();
    alu(vsel(2), 32'hAABBCCDD, 4'b0101); rSel1 = vsel(2);
    #3 check("masked same cycle", operand1, BYP ? 32'h00BB00DD : 32'h0);
    cyc(); idle();
    #3 check("masked v2", operand1, 32'h00BB00DD);

    // Scalar broadcast, mask ignored.
    cyc(); idle();
    alu(ssel(3), 32'h9999995A, 4'h0); rSel1 = ssel(3);
    cyc(); idle();
    #3 check("scalar broadcast", operand1, 32'h5A5A5A5A);

    // Arbitration: ALU wins, memory buffered then drained.
    cyc(); idle();
    alu(vsel(1), 32'h01020304, 4'hF); mem(vsel(4), 32'h40404040, 4'hF);
    rSel1 = vsel(1); rSel2 = vsel(4);
    #3 check("arb memReady", memReady, 1'b1);
    cyc(); idle();
    #3;
    check("arb alu committed", operand1, 32'h01020304);
    check("arb head draining", operand2, BYP ? 32'h40404040 : 32'h0);
    cyc();
    #3 check("arb v4 committed", operand2, 32'h40404040);

    // Fill the buffer with back-to-back ALU+mem cycles.
    cyc(); idle();
    alu(vsel(0), 32'h0A0A0A0A, 4'hF); mem(vsel(6), 32'h66666666, 4'hF);
    #3 check("fill c1 memReady", memReady, 1'b1);
    cyc();
    alu(vsel(0), 32'h0B0B0B0B, 4'hF); mem(vsel(7), 32'h77777777, 4'hF);
    #3 check("fill c2 memReady", memReady, 1'b1);
    cyc();
    alu(vsel(0), 32'h0C0C0C0C, 4'hF); mem(vsel(0), 32'hEEEEEEEE, 4'hF);
    #3 check("fill c3 full", memReady, 1'b0);
    cyc(); idle();
    mem(vsel(3), 32'h33333333, 4'hF);
    #3 check("full but draining", memReady, 1'b1);
    cyc(); idle(); rSel1 = vsel(6);
    #3 check("drain v6", operand1, 32'h66666666);
    cyc(); rSel1 = vsel(7); rSel2 = vsel(0);
    #3;
    check("drain v7", operand1, 32'h77777777);
    check("dropped mem left v0", operand2, 32'h0C0C0C0C);
    cyc(); rSel1 = vsel(3);
    #3 check("drain v3", operand1, 32'h33333333);

    // Scoreboard.
    cyc(); idle(); issue(vsel(5)); rSel1 = vsel(5);
    #3 check("issue v5 ready", issueReady, 1'b1);
    cyc(); idle(); issue(vsel(5));
    #3;
    check("waw stall", issueReady, 1'b0);
    check("v5 hazard", hazard1, 1'b1);
    cyc(); idle(); mem(vsel(5), 32'h55555555, 4'hF);
    #3 check("v5 hazard during write", hazard1, BYP ? 1'b0 : 1'b1);
    cyc(); idle();
    #3;
    check("v5 resolved", hazard1, 1'b0);
    check("v5 data", operand1, 32'h55555555);
    cyc(); idle(); issue(vsel(5)); alu(vsel(5), 32'h12345678, 4'h0);
    cyc(); idle();
    #3;
    check("set wins", hazard1, 1'b1);
    check("mask0 no data", operand1, 32'h55555555);
    cyc(); idle(); alu(vsel(5), 32'h0, 4'h0);
    cyc(); idle();
    #3 check("mask0 clears busy", hazard1, 1'b0);

    // Bypass on a busy scalar.
    cyc(); idle(); issue(ssel(7));
    cyc(); idle(); alu(ssel(7), 32'h0000003C, 4'hF); rSel2 = ssel(7);
    #3;
    check("bypass s7 data", operand2, BYP ? 32'h3C3C3C3C : 32'h0);
    check("bypass s7 hazard", hazard2, BYP ? 1'b0 : 1'b1);
    cyc(); idle();
    #3;
    check("s7 committed", operand2, 32'h3C3C3C3C);
    check("s7 resolved", hazard2, 1'b0);

    // Out-of-range vector index 9.
    cyc(); idle(); issue(vsel(9)); alu(vsel(9), 32'hFFFFFFFF, 4'hF);
    rSel1 = vsel(9); rSel2 = vsel(1);
    #3;
    check("oor issueReady", issueReady, 1'b1);
    check("oor read", operand1, 32'h0);
    cyc(); idle();
    #3;
    check("oor never busy", hazard1, 1'b0);
    check("oor read after", operand1, 32'h0);
    check("oor no alias v1", operand2, 32'h01020304);

    cyc(); cyc();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/vs_regfile_sb.md
Name: vs_regfile_sb

Overview:
Next-generation unified scalar/vector register file for the decode stage.
- Parametrised bank sizes, two read ports with scalar broadcast, per-lane write masks, and a per-register busy scoreboard for hazard detection.
- Two write sources (ALU/chip and memory) share a single physical write port; memory writes that lose arbitration are held in a small ordered pending buffer.
- Optional same-cycle write-to-read bypass.

Parameters:
registerSize, 8, bits per lane / per scalar register
vectorSize, 4, lanes per vector register
vecQuantity, 8, number of vector registers
scalarQuantity, 16, number of scalar registers
selectionBits, 5, register select width; MSB=1 selects scalar bank, MSB=0 selects vector bank; low bits index the bank
pendDepth, 2, memory pending-write buffer entries (>=1)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
rSel1, rSel2  in  selectionBits  read selects
operand1, operand2  out  vectorSize x registerSize  read data; scalar reads are broadcast to all lanes
hazard1, hazard2  out  1  selected register is busy and is not being resolved this cycle
issueValid  in  1  instruction issue; marks issueDest busy
issueDest  in  selectionBits  destination of the issuing instruction
issueReady  out  1  low when issueDest is already busy (WAW stall)
wrEnAlu  in  1  ALU/chip write request; always accepted
wrSelAlu  in  selectionBits  ALU destination
wrDataAlu  in  vectorSize x registerSize  ALU data; scalar writes use lane 0
wrMaskAlu  in  vectorSize  lane write mask; ignored for scalar destinations
wrEnMem, wrSelMem, wrDataMem, wrMaskMem  in  1 / selectionBits / vectorSize x registerSize / vectorSize  memory write request, same field meanings as the ALU port
memReady  out  1  high when a memory write is accepted this cycle (buffer not full)

Behaviour:
- Reset (asynchronous, active-low): all registers=0, busy bits=0, pending buffer empty, all pointers/count=0.
- Outputs during reset: operand1/operand2=0, hazard1/hazard2=0, issueReady=1, memReady=1.
- Reads are combinational from register state. A write commits at the rising edge and is visible on reads the cycle after, unless bypassed (see Optional Feature).
- Write-port arbitration each cycle, in priority order:
  - wrEnAlu set: ALU writes the port.
  - Else pending buffer non-empty: buffer head writes the port and is popped.
  - Else wrEnMem set: memory data writes the port directly.
- Memory request handling:
  - An accepted memory request that does not get the port is pushed to the buffer tail.
  - Memory order is preserved: if the buffer is non-empty, a new memory request is always pushed, never written directly.
  - memReady = count < pendDepth, or (count==pendDepth and the head drains this cycle).
  - wrEnMem while memReady=0: the request is dropped, with no state change.
  - The same cycle may both pop the head and push a new entry; count is unchanged.
- Masked vector write: lane i is updated only where mask[i]=1. Mask=0 writes nothing but still clears the busy bit.
- Scalar write: stores lane 0 of the data into the scalar register; the mask is ignored.
- Scoreboard:
  - Busy bit is cleared when a write to that register commits.
  - Busy bit is set on issueValid && issueReady.
  - Set and clear of the same register in one cycle: set wins.
  - issueValid while issueReady=0: ignored.
- hazardN = busy[rSelN] && !(bypass enabled && a port write to rSelN commits this cycle).
- Out-of-range bank index (e.g. vector index >= vecQuantity): read returns 0, write is discarded, busy bit is never set.

Optional Feature:
Macro: VS_REGFILE_BYPASS_EN
- Defined: when rSelN equals the register being written this cycle, operandN shows the post-write value. Masked lanes come from the write data; other lanes keep the old value. hazardN is suppressed for that register.
- Undefined: reads show only committed state, and hazardN stays high until the cycle after the write.

Test Plan:
- Reset: write V1=all 0x11, assert reset mid-stream -> operand1=0 on V1, memReady=1, issueReady=1, buffer empty.
- Masked vector write: ALU writes V2={0xAA,0xBB,0xCC,0xDD} mask 4'b0101 over V2=0 -> next cycle V2 reads {0x00,0xBB,0x00,0xDD} (lane0=0xDD).
- Scalar broadcast: ALU writes S3 with lane0=0x5A; rSel1=5'b10011 -> operand1=all lanes 0x5A.
- Arbitration: ALU writes V1 and memory writes V4 in the same cycle -> V1 commits and V4 is buffered. Next idle cycle V4 commits. With pendDepth=2 and three back-to-back ALU+mem cycles, memReady=0 on the third cycle.
- Scoreboard: issue to V5 -> hazard1=1 for rSel1=V5 and issueReady=0 for a second issue to V5. After the memory write to V5 commits, hazard1=0. Issue and write to V5 in the same cycle -> busy stays 1.
- Bypass (macro defined): ALU writes S7=0x3C while rSel2=S7 -> operand2=0x3C in the same cycle, hazard2=0. With the macro undefined: old value shown, hazard2=1.
